trigger_sequencer: RTL and testbench

Sequences playback triggers for the DAC channel controllers. On a PS arm command it issues a one-cycle `trigger_in` pulse to each channel controller at a programmable per-channel offset, and repeats the pattern at a programmable period for a programmable burst count. It sits between the gpio_ctrl decode logic and the `trigger_in` inputs of all channel controllers. It runs in the 250 MHz RFSoC fabric clock domain.

---
 rtl/rfsoc_config.sv | 17 +
 rtl/trigger_sequencer_burst_timer.sv | 53 +++++
 rtl/trigger_sequencer.sv | 124 ++++++++++++
 tb/tb_trigger_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_config.sv
// Shared configuration for the RFSoC fabric blocks: default widths and the
// trigger sequencer state encoding.
package rfsoc_config;

  localparam int unsigned NUM_CH_DEF   = 8;
  localparam int unsigned DELAY_W_DEF  = 16;
  localparam int unsigned PERIOD_W_DEF = 32;
  localparam int unsigned REPEAT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SYNC,
    RUN,
    DONE
  } trig_seq_state_t;

endpackage

// File: rtl/trigger_sequencer_burst_timer.sv
// Period/burst bookkeeping for trigger_sequencer: shadow period and repeat
// registers, the in-period counter and the period index.
module burst_timer
  import rfsoc_config::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned REPEAT_W = REPEAT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                run,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [REPEAT_W-1:0] cfg_repeat,
  output logic [PERIOD_W-1:0] cnt,
  output logic [REPEAT_W-1:0] period_idx,
  output logic                last
);

  logic [PERIOD_W-1:0] period_q;
  logic [REPEAT_W-1:0] repeat_q;
  logic                wrap;

  assign wrap = run && (cnt == period_q - PERIOD_W'(1));
  // repeat_q == 0 selects free-running mode, so no period is ever the last.
  assign last = wrap && (repeat_q != '0) && (period_idx == repeat_q - REPEAT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      period_q   <= '0;
      repeat_q   <= '0;
      cnt        <= '0;
      period_idx <= '0;
    end else if (clear) begin
      cnt        <= '0;
      period_idx <= '0;
    end else if (load) begin
      period_q   <= cfg_period;
      repeat_q   <= cfg_repeat;
      cnt        <= '0;
      period_idx <= '0;
    end else if (run) begin
      if (wrap) begin
        cnt <= '0;
        if (!last) period_idx <= period_idx + REPEAT_W'(1);
      end else begin
        cnt <= cnt + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/trigger_sequencer.sv
// Per-channel playback trigger sequencer with periodic bursts.
// Optional build macro TRIG_SEQ_EXT_SYNC_EN aligns each run to an ext_sync edge.
module trigger_sequencer
  import rfsoc_config::*;
#(
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned DELAY_W  = DELAY_W_DEF,
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned REPEAT_W = REPEAT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH*DELAY_W-1:0]  cfg_delay,
  input  logic [PERIOD_W-1:0]        cfg_period,
  input  logic [REPEAT_W-1:0]        cfg_repeat,
  input  logic                       arm,
  input  logic                       abort,
  input  logic                       ext_sync,
  output logic [NUM_CH-1:0]          trigger_out,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err,
  output logic [REPEAT_W-1:0]        period_idx
);

  localparam int unsigned CMP_W = (DELAY_W > PERIOD_W) ? DELAY_W : PERIOD_W;

`ifdef TRIG_SEQ_EXT_SYNC_EN
  localparam trig_seq_state_t ARM_NEXT = WAIT_SYNC;
`else
  localparam trig_seq_state_t ARM_NEXT = RUN;
`endif

  trig_seq_state_t           state, state_next;
  logic [NUM_CH*DELAY_W-1:0] delay_q;
  logic [PERIOD_W-1:0]       cnt;
  logic [NUM_CH-1:0]         hit;
  logic                      accept, reject, last, sync_edge;

  assign accept = (state == IDLE) && arm && !abort && (cfg_period != '0);
  assign reject = (state == IDLE) && arm && !abort && (cfg_period == '0);

`ifdef TRIG_SEQ_EXT_SYNC_EN
  logic ext_sync_q;

  always_ff @(posedge clk) begin
    if (rst) ext_sync_q <= 1'b0;
    else     ext_sync_q <= ext_sync;
  end

  assign sync_edge = ext_sync && !ext_sync_q;
`else
  logic unused_ext_sync;

  assign unused_ext_sync = ext_sync;
  assign sync_edge       = 1'b0;
`endif

  burst_timer #(
    .PERIOD_W (PERIOD_W),
    .REPEAT_W (REPEAT_W)
  ) u_burst_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .run        (state == RUN),
    .clear      (abort || (state == DONE)),
    .cfg_period (cfg_period),
    .cfg_repeat (cfg_repeat),
    .cnt        (cnt),
    .period_idx (period_idx),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:      if (accept) state_next = ARM_NEXT;
        WAIT_SYNC: if (sync_edge) state_next = RUN;
        RUN:       if (last) state_next = DONE;
        DONE:      state_next = IDLE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst)         delay_q <= '0;
    else if (accept) delay_q <= cfg_delay;
  end

  // cnt never reaches period, so an offset >= period simply never matches.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i] = (state == RUN) &&
               (CMP_W'(delay_q[i*DELAY_W +: DELAY_W]) == CMP_W'(cnt));
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) trigger_out <= '0;
    else              trigger_out <= hit;
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= reject;
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: vector table, directed corner
// sequences and randomized traffic against a timeline-based reference model.
module tb_trigger_sequencer;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 6;
  localparam int unsigned PW  = 8;
  localparam int unsigned RW  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0, arm = 1'b0, abort = 1'b0, ext_sync = 1'b0;
  logic [NCH*DW-1:0] cfg_delay = '0;
  logic [PW-1:0]     cfg_period = '0;
  logic [RW-1:0]     cfg_repeat = '0;
  logic [NCH-1:0]    trigger_out;
  logic              busy, done, cfg_err;
  logic [RW-1:0]     period_idx;

  int vectors = 0;
  int miscompares = 0;

  trigger_sequencer #(
    .NUM_CH   (NCH),
    .DELAY_W  (DW),
    .PERIOD_W (PW),
    .REPEAT_W (RW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_delay   (cfg_delay),
    .cfg_period  (cfg_period),
    .cfg_repeat  (cfg_repeat),
    .arm         (arm),
    .abort       (abort),
    .ext_sync    (ext_sync),
    .trigger_out (trigger_out),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .period_idx  (period_idx)
  );

  always #2 clk = ~clk;

  // Reference model: a run is a timeline position n (cycles since cnt was 0),
  // and every output is derived arithmetically from n, period and burst length.
  bit          m_active, m_wait, m_err, m_prev;
  longint      m_n;
  longint      m_P, m_R;
  int unsigned m_d [NCH];

  task automatic model_step(input bit r, input bit a, input bit ab, input bit s);
    m_err = 1'b0;
    if (r || ab) begin
      m_active = 1'b0;
      m_wait   = 1'b0;
    end else if (!m_active && !m_wait) begin
      if (a) begin
        if (cfg_period != 0) begin
          m_P = longint'(cfg_period);
          m_R = longint'(cfg_repeat);
          for (int i = 0; i < NCH; i++) m_d[i] = cfg_delay[i*DW +: DW];
`ifdef TRIG_SEQ_EXT_SYNC_EN
          m_wait = 1'b1;
`else
          m_active = 1'b1;
          m_n      = 0;
`endif
        end else begin
          m_err = 1'b1;
        end
      end
    end else if (m_wait) begin
      if (s && !m_prev) begin
        m_wait   = 1'b0;
        m_active = 1'b1;
        m_n      = 0;
      end
    end else begin
      m_n++;
      if (m_R != 0 && m_n > m_R * m_P) m_active = 1'b0;
    end
    m_prev = r ? 1'b0 : s;
  endtask

  function automatic logic [10:0] model_out();
    logic           e_busy, e_done, running;
    logic [RW-1:0]  e_idx;
    logic [NCH-1:0] e_trig;
    e_busy  = m_active || m_wait;
    e_done  = m_active && (m_R != 0) && (m_n == m_R * m_P);
    running = m_active && (m_R == 0 || m_n < m_R * m_P);
    if (running)     e_idx = RW'((m_n / m_P) % (longint'(1) << RW));
    else if (e_done) e_idx = RW'(m_R - 1);
    else             e_idx = '0;
    e_trig = '0;
    if (m_active && m_n >= 1 && (m_R == 0 || m_n - 1 < m_R * m_P))
      for (int i = 0; i < NCH; i++)
        if ((m_n - 1) % m_P == longint'(m_d[i])) e_trig[i] = 1'b1;
    return {e_busy, e_done, m_err, e_idx, e_trig};
  endfunction

  function automatic logic [10:0] dut_out();
    return {busy, done, cfg_err, period_idx, trigger_out};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cyc(input bit r, input bit a, input bit ab);
    rst   = r;
    arm   = a;
    abort = ab;
    @(posedge clk);
    model_step(r, a, ab, ext_sync);
    #1;
    check("model", 64'(dut_out()), 64'(model_out()));
  endtask

  task automatic arm_run();
    ext_sync = 1'b0;
    cyc(0, 1, 0);
`ifdef TRIG_SEQ_EXT_SYNC_EN
    ext_sync = 1'b1;
    cyc(0, 0, 0);
    ext_sync = 1'b0;
`endif
  endtask

  typedef struct {
    bit             r, a, ab;
    logic [PW-1:0]  per;
    logic           b, d, e;
    logic [RW-1:0]  idx;
    logic [NCH-1:0] tr;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int pulses, dones, viol;
    int ptime [$];
    int idxs [$];

    // Single period of 10, one burst; delays 0,3,9,12 (12 >= period never fires).
    tbl[0]  = '{1, 0, 0, 10, 0, 0, 0, 0, 4'b0000};
    tbl[1]  = '{0, 1, 0,  0, 0, 0, 1, 0, 4'b0000};
    tbl[2]  = '{0, 0, 0, 10, 0, 0, 0, 0, 4'b0000};
    tbl[3]  = '{0, 1, 1, 10, 0, 0, 0, 0, 4'b0000};
    tbl[4]  = '{0, 0, 0, 10, 0, 0, 0, 0, 4'b0000};
    tbl[5]  = '{0, 1, 0, 10, 1, 0, 0, 0, 4'b0000};
    tbl[6]  = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0001};
    tbl[7]  = '{0, 1, 0,  0, 1, 0, 0, 0, 4'b0000};
    tbl[8]  = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0000};
    tbl[9]  = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0010};
    tbl[10] = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0000};
    tbl[11] = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0000};
    tbl[12] = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0000};
    tbl[13] = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0000};
    tbl[14] = '{0, 0, 0,  3, 1, 0, 0, 0, 4'b0000};
    tbl[15] = '{0, 0, 0,  3, 1, 1, 0, 0, 4'b0100};
    tbl[16] = '{0, 0, 0,  3, 0, 0, 0, 0, 4'b0000};

    cfg_delay  = {6'd12, 6'd9, 6'd3, 6'd0};
    cfg_repeat = 4'd1;
    cfg_period = 8'd10;
    cyc(1, 0, 0);
    check("reset_outputs", 64'(dut_out()), 64'd0);

`ifndef TRIG_SEQ_EXT_SYNC_EN
    for (int k = 0; k < 17; k++) begin
      cfg_period = tbl[k].per;
      cyc(tbl[k].r, tbl[k].a, tbl[k].ab);
      check($sformatf("table[%0d]", k), 64'(dut_out()),
            64'({tbl[k].b, tbl[k].d, tbl[k].e, tbl[k].idx, tbl[k].tr}));
    end
`endif

    // Finite burst: period 4, 3 periods, only ch0 (delay 1) in range.
    cfg_period = 8'd4;
    cfg_repeat = 4'd3;
    cfg_delay  = {6'd63, 6'd4, 6'd40, 6'd1};
    cyc(0, 0, 0);
    arm_run();
    pulses = 0;
    dones  = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(0, 0, 0);
      if (trigger_out[0]) begin pulses++; ptime.push_back(c); end
      if (done) dones++;
      if (busy && !done && (idxs.size() == 0 || idxs[$] != int'(period_idx)))
        idxs.push_back(int'(period_idx));
    end
    check("burst_pulses", 64'(pulses), 64'd3);
    check("burst_done_count", 64'(dones), 64'd1);
    if (ptime.size() == 3) begin
      check("burst_spacing_a", 64'(ptime[1] - ptime[0]), 64'd4);
      check("burst_spacing_b", 64'(ptime[2] - ptime[1]), 64'd4);
    end
    check("burst_idx_len", 64'(idxs.size()), 64'd3);
    for (int i = 0; i < idxs.size() && i < 3; i++)
      check($sformatf("burst_idx[%0d]", i), 64'(idxs[i]), 64'(i));

    // Abort in infinite mode, 13 cycles after the arm.
    cfg_period = 8'd5;
    cfg_repeat = 4'd0;
    cfg_delay  = {6'd1, 6'd4, 6'd2, 6'd0};
    cyc(0, 1, 0);
    for (int c = 1; c < 13; c++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    check("abort_busy", 64'(busy), 64'd0);
    viol = 0;
    for (int c = 0; c < 16; c++) begin
      cyc(0, 0, 0);
      if (trigger_out != 0 || done || busy) viol++;
    end
    check("abort_quiet", 64'(viol), 64'd0);

    // Period 1 in free-running mode: ch0 fires every cycle, period_idx wraps.
    cfg_period = 8'd1;
    cfg_delay  = {6'd1, 6'd1, 6'd1, 6'd0};
    arm_run();
    for (int c = 0; c < 40; c++) cyc(0, 0, 0);
    cyc(0, 0, 1);

`ifdef TRIG_SEQ_EXT_SYNC_EN
    // Edge in the arm cycle is ignored; the run starts on the next edge.
    cfg_period = 8'd10;
    cfg_repeat = 4'd1;
    cfg_delay  = {6'd12, 6'd9, 6'd3, 6'd0};
    ext_sync = 1'b1;
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    ext_sync = 1'b0;
    viol = 0;
    for (int c = 0; c < 4; c++) begin
      cyc(0, 0, 0);
      if (trigger_out != 0 || !busy) viol++;
    end
    check("sync_waits", 64'(viol), 64'd0);
    ext_sync = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) ext_sync = 1'b0;
      cyc(0, 0, 0);
      if (trigger_out[0]) begin
        pulses++;
        check("sync_ch0_time", 64'(c), 64'd1);
      end
    end
    check("sync_ch0_pulses", 64'(pulses), 64'd1);
    cyc(0, 0, 1);
`endif

    // Reset in the middle of a run, then a fresh single-period arm.
    cfg_period = 8'd10;
    cfg_repeat = 4'd1;
    cfg_delay  = {6'd12, 6'd9, 6'd3, 6'd0};
    arm_run();
    for (int c = 0; c < 4; c++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("midrun_reset", 64'(dut_out()), 64'd0);
`ifndef TRIG_SEQ_EXT_SYNC_EN
    for (int k = 5; k < 17; k++) begin
      cyc(0, tbl[k].a, tbl[k].ab);
      check($sformatf("rearm[%0d]", k), 64'(dut_out()),
            64'({tbl[k].b, tbl[k].d, tbl[k].e, tbl[k].idx, tbl[k].tr}));
    end
`endif

    // Randomized traffic; cfg_* changes every cycle to exercise shadowing.
    for (int c = 0; c < 3000; c++) begin
      cfg_period = PW'($urandom_range(0, 12));
      if ($urandom_range(0, 9) == 0) cfg_period = '0;
      cfg_repeat = RW'($urandom_range(0, 4));
      for (int i = 0; i < NCH; i++) cfg_delay[i*DW +: DW] = DW'($urandom_range(0, 15));
      ext_sync = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 79) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
